// File: rtl/log_axi_pkg.sv
// Shared types and constants for the log memory AXI4-Lite read path.
package log_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } rd_state_e;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_EXOKAY = 2'b01;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    // Log words are 32 bits wide, so a word index becomes a byte offset by shifting by 2.
    localparam int WORD_SHIFT = 2;

    // Byte address of a log word; the result wraps modulo 2^32, dropping the top index bits.
    function automatic logic [31:0] word_to_byte(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << WORD_SHIFT);
    endfunction

    // SLVERR and DECERR are errors; OKAY and EXOKAY are clean completions.
    function automatic logic rresp_is_err(input logic [1:0] resp);
        return (resp == RRESP_SLVERR) || (resp == RRESP_DECERR);
    endfunction

endpackage

// File: rtl/log_rd_timer.sv
// Watchdog counter for a single read transaction: cleared while idle, counts while
// the transaction is outstanding and flags expiry once TIMEOUT cycles have elapsed.
module log_rd_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] count_q;

    // Count enabled cycles, saturating at TIMEOUT so a late handshake cannot wrap the count.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i && (count_q < LIMIT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Expiry fires on the edge where the count would reach TIMEOUT (or has already).
    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign expire_o = 1'b0;
        end else begin : g_timeout
            assign expire_o = en_i && (count_q >= LAST);
        end
    endgenerate

endmodule

// File: rtl/log_axi_reader.sv
// Single-outstanding AXI4-Lite read master serving the log_accesser memory port:
// one trigger produces one AR/R transaction and one done pulse with data and error.
module log_axi_reader
    import log_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read_trigger,
    input  logic [31:0] i_mem_addr,
    output logic [31:0] o_mem_value,
    output logic        o_done,
    output logic        o_error,
    output logic        o_busy,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);
    rd_state_e   state_q;
    logic [31:0] value_q;
    logic        done_q;
    logic        error_q;
    logic        busy_q;
    logic [31:0] araddr_q;
    logic        arvalid_q;
    logic        rready_q;

    logic [31:0] araddr_d;
    logic        expire;

    assign araddr_d = word_to_byte(BASE_ADDR, i_mem_addr);

    log_rd_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n_i  (rst),
        .clr_i    (state_q == ST_IDLE),
        .en_i     ((state_q == ST_ADDR) || (state_q == ST_DATA)),
        .expire_o (expire)
    );

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            value_q   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_read_trigger) begin
                        araddr_q  <= araddr_d;
                        arvalid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // A handshake on the expiry edge takes the normal path.
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_DATA;
                    end else if (expire) begin
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        value_q <= '0;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DATA: begin
                    if (m_axi_rvalid) begin
                        value_q  <= m_axi_rdata;
                        error_q  <= rresp_is_err(m_axi_rresp);
                        rready_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_RESP;
                    end else if (expire) begin
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        value_q <= '0;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_DRAIN: begin
                    // Finish the abandoned transfer on the bus without reporting it.
                    if (arvalid_q) begin
                        if (m_axi_arready) begin
                            arvalid_q <= 1'b0;
                            rready_q  <= 1'b1;
                        end
                    end else if (m_axi_rvalid) begin
                        rready_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mem_value   = value_q;
    assign o_done        = done_q;
    assign o_error       = error_q;
    assign o_busy        = busy_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_log_axi_reader.sv
// Scoreboard bench for log_axi_reader: a stimulus process issues reads and queues the
// expected AR address and completion, a slave process answers on AXI with scripted
// delays, and a monitor process checks every done pulse against the queued result.
module tb_log_axi_reader;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          TO   = 16;

    typedef struct {
        int          ar_dly;
        int          r_dly;
        logic [31:0] data;
        logic [1:0]  resp;
    } cfg_t;

    typedef struct {
        logic [31:0] val;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_read_trigger = 1'b0;
    logic [31:0] i_mem_addr = '0;
    logic [31:0] o_mem_value;
    logic        o_done;
    logic        o_error;
    logic        o_busy;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    cfg_t        cfg_q[$];
    logic [31:0] ar_q[$];
    exp_t        exp_q[$];

    log_axi_reader #(
        .BASE_ADDR (BASE),
        .TIMEOUT   (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_read_trigger (i_read_trigger),
        .i_mem_addr     (i_mem_addr),
        .o_mem_value    (o_mem_value),
        .o_done         (o_done),
        .o_error        (o_error),
        .o_busy         (o_busy),
        .m_axi_araddr   (m_axi_araddr),
        .m_axi_arprot   (m_axi_arprot),
        .m_axi_arvalid  (m_axi_arvalid),
        .m_axi_arready  (m_axi_arready),
        .m_axi_rdata    (m_axi_rdata),
        .m_axi_rresp    (m_axi_rresp),
        .m_axi_rvalid   (m_axi_rvalid),
        .m_axi_rready   (m_axi_rready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: the read completes when the R beat lands within TO cycles of the
    // trigger edge; otherwise it reports error with value 0 exactly TO cycles later.
    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                           input logic [31:0] data, input logic [1:0] resp,
                           input bit extra, input bit expect_done);
        cfg_t c;
        exp_t e;
        int   n;
        int   k;
        int   total;
        n = 0;
        while (o_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("idle_wait_timeout", 32'd1, 32'd0);
        c.ar_dly = ar_dly;
        c.r_dly  = r_dly;
        c.data   = data;
        c.resp   = resp;
        cfg_q.push_back(c);
        ar_q.push_back(BASE + (addr * 32'd4));
        k     = cyc + 1;
        total = (ar_dly + 1) + (r_dly + 1);
        if (expect_done) begin
            if (total <= TO) begin
                e.val = data;
                e.err = (resp >= 2'd2);
                e.cyc = k + total;
            end else begin
                e.val = 32'd0;
                e.err = 1'b1;
                e.cyc = k + TO;
            end
            exp_q.push_back(e);
        end
        i_read_trigger = 1'b1;
        i_mem_addr     = addr;
        @(negedge clk);
        if (extra) begin
            i_mem_addr = 32'd5;
            @(negedge clk);
        end
        i_read_trigger = 1'b0;
    endtask

    // AXI slave: answers each AR with the next scripted delays and data; abandons on reset.
    initial begin
        cfg_t        c;
        logic [31:0] ea;
        bit          ok;
        int          n;
        forever begin
            @(negedge clk);
            if (rst && m_axi_arvalid) begin
                ok = 1'b1;
                if (cfg_q.size() == 0 || ar_q.size() == 0) begin
                    chk("unexpected_ar", 32'd1, 32'd0);
                    c.ar_dly = 0; c.r_dly = 0; c.data = '0; c.resp = '0;
                    ea = m_axi_araddr;
                end else begin
                    c  = cfg_q.pop_front();
                    ea = ar_q.pop_front();
                end
                chk("araddr", m_axi_araddr, ea);
                chk("arprot", {29'd0, m_axi_arprot}, 32'd0);
                for (int i = 0; i < c.ar_dly && ok; i++) begin
                    @(negedge clk);
                    if (!rst) ok = 1'b0;
                    else begin
                        chk("arvalid_held", {31'd0, m_axi_arvalid}, 32'd1);
                        chk("araddr_stable", m_axi_araddr, ea);
                    end
                end
                if (ok) begin
                    m_axi_arready = 1'b1;
                    @(negedge clk);
                    m_axi_arready = 1'b0;
                    if (!rst) ok = 1'b0;
                end
                for (int i = 0; i < c.r_dly && ok; i++) begin
                    @(negedge clk);
                    if (!rst) ok = 1'b0;
                end
                if (ok) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = c.data;
                    m_axi_rresp  = c.resp;
                    n = 0;
                    while (ok && !m_axi_rready && n < 200) begin
                        @(negedge clk);
                        n++;
                        if (!rst) ok = 1'b0;
                    end
                    if (ok && m_axi_rready) @(negedge clk);
                    else if (ok) chk("rready_wait_timeout", 32'd1, 32'd0);
                end
                m_axi_arready = 1'b0;
                m_axi_rvalid  = 1'b0;
            end
        end
    end

    // Monitor: every done pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_value", o_mem_value, e.val);
                    chk("done_error", {31'd0, o_error}, {31'd0, e.err});
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_at_done", {31'd0, o_busy}, 32'd1);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] a;
        int          ad;
        repeat (3) @(negedge clk);
        chk("rst_done",    {31'd0, o_done},        32'd0);
        chk("rst_error",   {31'd0, o_error},       32'd0);
        chk("rst_value",   o_mem_value,            32'd0);
        chk("rst_busy",    {31'd0, o_busy},        32'd0);
        chk("rst_arvalid", {31'd0, m_axi_arvalid}, 32'd0);
        chk("rst_rready",  {31'd0, m_axi_rready},  32'd0);
        chk("rst_araddr",  m_axi_araddr,           32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed cases.
        do_read(32'd4, 0, 0, 32'h0000_00FF, 2'b00, 1'b0, 1'b1);
        do_read(32'd8, 3, 0, 32'h1234_5678, 2'b00, 1'b0, 1'b1);
        do_read(32'd1, 0, 2, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b1);
        do_read(32'd2, 1, 1, 32'hCAFE_0001, 2'b11, 1'b0, 1'b1);
        do_read(32'd3, 0, 0, 32'hCAFE_0002, 2'b01, 1'b0, 1'b1);
        do_read(32'hC000_0007, 0, 0, 32'h0BAD_F00D, 2'b00, 1'b0, 1'b1);
        do_read(32'd9, 0, 14, 32'hAAAA_5555, 2'b00, 1'b0, 1'b1);
        do_read(32'd10, 0, 15, 32'h5555_AAAA, 2'b00, 1'b0, 1'b1);
        do_read(32'd11, 0, 20, 32'h1111_2222, 2'b00, 1'b0, 1'b1);
        do_read(32'd12, 20, 0, 32'h3333_4444, 2'b00, 1'b0, 1'b1);
        do_read(32'd6, 1, 2, 32'h7777_8888, 2'b00, 1'b1, 1'b1);
        do_read(32'd5, 0, 0, 32'h9999_0000, 2'b00, 1'b0, 1'b1);

        // Reset while waiting for the R beat.
        do_read(32'd7, 0, 10, 32'hFFFF_0000, 2'b00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_arvalid", {31'd0, m_axi_arvalid}, 32'd0);
        chk("midrst_rready",  {31'd0, m_axi_rready},  32'd0);
        chk("midrst_busy",    {31'd0, o_busy},        32'd0);
        chk("midrst_done",    {31'd0, o_done},        32'd0);
        chk("midrst_value",   o_mem_value,            32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_read(32'd13, 0, 0, 32'h600D_600D, 2'b00, 1'b0, 1'b1);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            a  = $urandom;
            ad = ($urandom_range(0, 4) == 0) ? $urandom_range(17, 20) : $urandom_range(0, 5);
            do_read(a, ad, $urandom_range(0, 18), $urandom, 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0), 1'b1);
        end

        n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("final_drain_timeout", 32'd1, 32'd0);
        repeat (5) @(negedge clk);
        chk("left_exp",  exp_q.size(), 32'd0);
        chk("left_cfg",  cfg_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
